// File: rtl/bram_bank_ctrl.sv
// bram_bank_ctrl: N-bank capture sequencer for the receiver BRAM path.
// Within each sync window it enables the banks one at a time and pulses the
// shared address-counter reset between banks. It also flags each bank ready
// as that bank fills. When the window closes it reports the captured word
// count, including a partially filled bank.
// Optional build macro: OVERRUN_CNT_EN adds the dropped-window counter.
// Without it, overrun_cnt is tied to zero.
module bram_bank_ctrl #(
    parameter int unsigned NUM_BANKS      = 2,
    parameter int unsigned DEPTH          = 2048,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned SIZE_W         = 32,
    parameter int unsigned OVF_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sinc,
    input  logic                 sinc_edge,
    input  logic [31:0]          addr,
    output logic                 rst_count,
    output logic [NUM_BANKS-1:0] bank_en,
    input  logic [NUM_BANKS-1:0] rdy_w,
    output logic [NUM_BANKS-1:0] rdy,
    output logic [SIZE_W-1:0]    size_data,
    output logic                 frame_done,
    output logic [OVF_W-1:0]     overrun_cnt
);

    localparam int unsigned IDX_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SHIFT  = $clog2(BYTES_PER_WORD);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BANKS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [SIZE_W-1:0] DEPTH_S  = SIZE_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1
    } state_e;

    state_e                state_q,      state_d;
    logic [IDX_W-1:0]      bank_idx_q,   bank_idx_d;
    logic [NUM_BANKS-1:0]  bank_en_q,    bank_en_d;
    logic                  rst_count_q,  rst_count_d;
    logic [NUM_BANKS-1:0]  rdy_q,        rdy_d;
    logic [SIZE_W-1:0]     size_data_q,  size_data_d;
    logic                  frame_done_q, frame_done_d;

    logic                  drop_c;
    logic                  bad_state_c;
    logic [CNT_W-1:0]      word_cnt_c;
    logic [SIZE_W-1:0]     part_words_c;

    // Words held by the partial bank: byte address to word index plus one, clamped to DEPTH
    always_comb begin
        word_cnt_c   = CNT_W'(addr >> SHIFT) + CNT_W'(1);
        part_words_c = (word_cnt_c > DEPTH_C) ? DEPTH_S : SIZE_W'(word_cnt_c);
    end

    // Next-state and output decode for the IDLE/FILL sequencer
    always_comb begin
        state_d      = state_q;
        bank_idx_d   = bank_idx_q;
        bank_en_d    = bank_en_q;
        rst_count_d  = rst_count_q;
        rdy_d        = rdy_q;
        size_data_d  = size_data_q;
        frame_done_d = 1'b0;
        drop_c       = 1'b0;
        bad_state_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rst_count_d = 1'b1;
                bank_en_d   = '0;
                if (sinc_edge) begin
                    if (rdy_w == '0) begin
                        rst_count_d = 1'b0;
                        bank_en_d   = NUM_BANKS'(1);
                        bank_idx_d  = '0;
                        rdy_d       = '0;
                        size_data_d = '0;
                        state_d     = ST_FILL;
                    end else begin
                        // Consumer still draining: this window is dropped
                        drop_c = 1'b1;
                    end
                end
            end

            ST_FILL: begin
                if (!sinc) begin
                    // Window closed early; the current bank is counted as partial
                    size_data_d = size_data_q + part_words_c;
                    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                        if (IDX_W'(i) <= bank_idx_q) begin
                            rdy_d[i] = 1'b1;
                        end
                    end
                    bank_en_d    = '0;
                    rst_count_d  = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (en) begin
                    size_data_d       = size_data_q + DEPTH_S;
                    rdy_d[bank_idx_q] = 1'b1;
                    if (bank_idx_q == LAST_IDX) begin
                        bank_en_d    = '0;
                        rst_count_d  = 1'b1;
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        // Advance to the next bank and restart the address counter for one cycle
                        bank_idx_d  = bank_idx_q + IDX_W'(1);
                        bank_en_d   = bank_en_q << 1;
                        rst_count_d = 1'b1;
                    end
                end else begin
                    rst_count_d = 1'b0;
                end
            end

            default: begin
                // Unreachable encoding: fall back to the reset condition
                bad_state_c = 1'b1;
                state_d     = ST_IDLE;
                bank_idx_d  = '0;
                bank_en_d   = '0;
                rst_count_d = 1'b1;
                rdy_d       = '0;
                size_data_d = '0;
            end
        endcase
    end

    // Sequencer state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bank_idx_q   <= '0;
            bank_en_q    <= '0;
            rst_count_q  <= 1'b1;
            rdy_q        <= '0;
            size_data_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_idx_q   <= bank_idx_d;
            bank_en_q    <= bank_en_d;
            rst_count_q  <= rst_count_d;
            rdy_q        <= rdy_d;
            size_data_q  <= size_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rst_count  = rst_count_q;
    assign bank_en    = bank_en_q;
    assign rdy        = rdy_q;
    assign size_data  = size_data_q;
    assign frame_done = frame_done_q;

`ifdef OVERRUN_CNT_EN
    logic [OVF_W-1:0] overrun_cnt_q, overrun_cnt_d;

    // Saturating count of windows dropped because the consumer was busy
    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (bad_state_c) begin
            overrun_cnt_d = '0;
        end else if (drop_c && (overrun_cnt_q != '1)) begin
            overrun_cnt_d = overrun_cnt_q + OVF_W'(1);
        end
    end

    // Overrun counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_cnt_q <= '0;
        end else begin
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
`else
    logic unused_drop_c;
    assign unused_drop_c = drop_c | bad_state_c;
    assign overrun_cnt   = '0;
`endif

endmodule

// File: tb/tb_bram_bank_ctrl.sv
// tb_bram_bank_ctrl: scoreboard bench for bram_bank_ctrl.
// Two instances, with 2 and 4 banks, share one stimulus stream. Each
// expectation names the instance it applies to.
module tb_bram_bank_ctrl;

`ifdef OVERRUN_CNT_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sinc;
    logic        sinc_edge;
    logic [31:0] addr;
    logic [3:0]  rdy_w;

    logic        rc2,   rc4;
    logic [1:0]  ben2,  rdy2;
    logic [3:0]  ben4,  rdy4;
    logic [31:0] size2, size4;
    logic        fd2,   fd4;
    logic [15:0] ovf2,  ovf4;

    bram_bank_ctrl #(.NUM_BANKS(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .sinc(sinc), .sinc_edge(sinc_edge),
        .addr(addr), .rst_count(rc2), .bank_en(ben2), .rdy_w(rdy_w[1:0]),
        .rdy(rdy2), .size_data(size2), .frame_done(fd2), .overrun_cnt(ovf2)
    );

    bram_bank_ctrl #(.NUM_BANKS(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .sinc(sinc), .sinc_edge(sinc_edge),
        .addr(addr), .rst_count(rc4), .bank_en(ben4), .rdy_w(rdy_w),
        .rdy(rdy4), .size_data(size4), .frame_done(fd4), .overrun_cnt(ovf4)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          big;
        logic        rc;
        logic [3:0]  ben;
        logic [3:0]  rdy;
        logic [31:0] size;
        logic        fd;
        logic [15:0] ovf;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input bit big, input logic rc,
                              input logic [3:0] ben, input logic [3:0] rdy_e,
                              input logic [31:0] size, input logic fd, input logic [15:0] ovf);
        exp_t e;
        e.tag  = tag;
        e.big  = big;
        e.rc   = rc;
        e.ben  = ben;
        e.rdy  = rdy_e;
        e.size = size;
        e.fd   = fd;
        e.ovf  = ovf;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs, then retire every pending expectation against the registered outputs
    task automatic cyc(input logic r, input logic se, input logic s, input logic n,
                       input logic [31:0] a, input logic [3:0] w);
        exp_t e;
        rst       = r;
        sinc_edge = se;
        sinc      = s;
        en        = n;
        addr      = a;
        rdy_w     = w;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.big) begin
                check_eq({e.tag, ".rst_count"},   64'(rc4),   64'(e.rc));
                check_eq({e.tag, ".bank_en"},     64'(ben4),  64'(e.ben));
                check_eq({e.tag, ".rdy"},         64'(rdy4),  64'(e.rdy));
                check_eq({e.tag, ".size_data"},   64'(size4), 64'(e.size));
                check_eq({e.tag, ".frame_done"},  64'(fd4),   64'(e.fd));
                check_eq({e.tag, ".overrun_cnt"}, 64'(ovf4),  64'(e.ovf));
            end else begin
                check_eq({e.tag, ".rst_count"},   64'(rc2),   64'(e.rc));
                check_eq({e.tag, ".bank_en"},     64'(ben2),  64'(e.ben));
                check_eq({e.tag, ".rdy"},         64'(rdy2),  64'(e.rdy));
                check_eq({e.tag, ".size_data"},   64'(size2), 64'(e.size));
                check_eq({e.tag, ".frame_done"},  64'(fd2),   64'(e.fd));
                check_eq({e.tag, ".overrun_cnt"}, 64'(ovf2),  64'(e.ovf));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset held two cycles, then idle
        cyc(1, 0, 0, 0, 0, 0);
        expect_out("t1_rst", 0, 1, 4'h0, 4'h0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        expect_out("t1_idle2", 0, 1, 4'h0, 4'h0, 0, 0, 0);
        expect_out("t1_idle4", 1, 1, 4'h0, 4'h0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Two-bank full window; a second edge inside FILL is ignored
        expect_out("t2_start", 0, 0, 4'h1, 4'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        expect_out("t2_edge_in_fill", 0, 0, 4'h1, 4'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        expect_out("t2_en0", 0, 1, 4'h2, 4'h1, 2048, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        expect_out("t2_rc_drop", 0, 0, 4'h2, 4'h1, 2048, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        expect_out("t2_en1", 0, 1, 4'h0, 4'h3, 4096, 1, 0);
        cyc(0, 0, 1, 1, 0, 0);
        expect_out("t2_idle", 0, 1, 4'h0, 4'h3, 4096, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Early close in bank0
        expect_out("t3_start", 0, 0, 4'h1, 4'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        expect_out("t3_close", 0, 1, 4'h0, 4'h1, 256, 1, 0);
        cyc(0, 0, 0, 0, 32'h3FC, 0);
        expect_out("t3_idle", 0, 1, 4'h0, 4'h1, 256, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Early close in bank1, then the clamped case
        expect_out("t4a_start", 0, 0, 4'h1, 4'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        expect_out("t4a_en0", 0, 1, 4'h2, 4'h1, 2048, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        expect_out("t4a_close", 0, 1, 4'h0, 4'h3, 2050, 1, 0);
        cyc(0, 0, 0, 0, 32'h7, 0);
        expect_out("t4b_start", 0, 0, 4'h1, 4'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        expect_out("t4b_en0", 0, 1, 4'h2, 4'h1, 2048, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        expect_out("t4b_clamp", 0, 1, 4'h0, 4'h3, 4096, 1, 0);
        cyc(0, 0, 0, 0, 32'hFFFC, 0);
        // Exactly DEPTH words from the address path
        expect_out("t4c_start", 0, 0, 4'h1, 4'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        expect_out("t4c_exact", 0, 1, 4'h0, 4'h1, 2048, 1, 0);
        cyc(0, 0, 0, 0, 32'h1FFC, 0);
        // sinc low together with en: the address count wins
        expect_out("t4d_start", 0, 0, 4'h1, 4'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        expect_out("t4d_both", 0, 1, 4'h0, 4'h1, 5, 1, 0);
        cyc(0, 0, 0, 1, 32'h10, 0);

        // Dropped windows while the consumer is busy
        expect_out("t5_rst", 0, 1, 4'h0, 4'h0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            expect_out($sformatf("t5_drop%0d", k), 0, 1, 4'h0, 4'h0, 0, 0,
                       OVF_ON ? 16'(k) : 16'd0);
            cyc(0, 1, 1, 0, 0, 4'h1);
            expect_out($sformatf("t5_gap%0d", k), 0, 1, 4'h0, 4'h0, 0, 0,
                       OVF_ON ? 16'(k) : 16'd0);
            cyc(0, 0, 0, 0, 0, 4'h1);
        end

        // Four-bank full window
        expect_out("t6_rst", 1, 1, 4'h0, 4'h0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        expect_out("t6_start", 1, 0, 4'h1, 4'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        expect_out("t6_en0", 1, 1, 4'h2, 4'h1, 2048, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        expect_out("t6_en1", 1, 1, 4'h4, 4'h3, 4096, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        expect_out("t6_hold", 1, 0, 4'h4, 4'h3, 4096, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        expect_out("t6_en2", 1, 1, 4'h8, 4'h7, 6144, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        expect_out("t6_en3", 1, 1, 4'h0, 4'hF, 8192, 1, 0);
        cyc(0, 0, 1, 1, 0, 0);
        expect_out("t6_idle", 1, 1, 4'h0, 4'hF, 8192, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // Early close in bank2 marks banks 0..2 ready
        expect_out("t6b_start", 1, 0, 4'h1, 4'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        expect_out("t6b_en0", 1, 1, 4'h2, 4'h1, 2048, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        expect_out("t6b_en1", 1, 1, 4'h4, 4'h3, 4096, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        expect_out("t6b_close", 1, 1, 4'h0, 4'h7, 4097, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // Reset in the middle of FILL
        expect_out("t6c_start", 1, 0, 4'h1, 4'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        expect_out("t6c_en0", 1, 1, 4'h2, 4'h1, 2048, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        expect_out("t6c_midrst", 1, 1, 4'h0, 4'h0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        expect_out("t6c_after", 1, 1, 4'h0, 4'h0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
